// File: rtl/cnt_sched_pkg.sv
// Shared types and helpers for the counter time-share scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FSM state enum, default sizing constants, one-hot to index helper.
package cnt_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 8;
    // Largest supported requester count; sizes the one-hot helper argument.
    localparam int MAX_REQ     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // OR of set-bit positions; exact for a one-hot (or all-zero) input.
    function automatic logic [2:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cnt_sched_arb.sv
// Winner selection among eligible requesters (round-robin or fixed priority).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the FSM only consults the result while idle.
// Ports: elig_i eligible vector, rr_ptr_i last winner (round-robin build only),
//        win_oh_o one-hot winner, win_idx_o winner index, win_vld_o any eligible.
// Build option: CNT_SCHED_FIXED_PRIO_EN selects lowest-index-wins, no pointer.
module cnt_sched_arb
    import cnt_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
`ifndef CNT_SCHED_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]   rr_ptr_i,
`endif
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               win_vld_o
);

`ifdef CNT_SCHED_FIXED_PRIO_EN
    // Walk downward so the lowest eligible index is the last to overwrite.
    always_comb begin
        win_oh_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                win_oh_o    = '0;
                win_oh_o[i] = 1'b1;
            end
        end
    end
`else
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        win_oh_o = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && elig_i[cand_idx]) begin
                win_oh_o[cand_idx] = 1'b1;
                found              = 1'b1;
            end
        end
    end
`endif

    assign win_vld_o = |elig_i;
    assign win_idx_o = IDX_W'(oh2idx(MAX_REQ'(win_oh_o)));

endmodule

// File: rtl/cnt_sched.sv
// Time-shares one up-counter among NUM_REQ requesters; the winner sees count 0..L.
// Latency: req to gnt 1 cycle; final count to done 1 cycle; done to next gnt >= 1 cycle.
// Backpressure: none; losers simply keep req high, dropping req mid-run cancels.
// Ports: clk, reset (sync, active-high), req/req_len in; gnt/done/count/busy out.
// Build option: CNT_SCHED_FIXED_PRIO_EN selects fixed priority (no rr pointer).
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [CNT_W-1:0]         count,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

    // A requester completing this cycle must not immediately win again.
    assign elig = req & ~done_q;

`ifndef CNT_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_q, rr_d;
`endif

    cnt_sched_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .elig_i    (elig),
`ifndef CNT_SCHED_FIXED_PRIO_EN
        .rr_ptr_i  (rr_q),
`endif
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        len_d   = len_q;
        busy_d  = busy_q;
`ifndef CNT_SCHED_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = RUN;
                    gnt_d   = win_oh;
                    busy_d  = 1'b1;
                    count_d = '0;
                    len_d   = req_len[win_idx*CNT_W +: CNT_W];
`ifndef CNT_SCHED_FIXED_PRIO_EN
                    rr_d    = win_idx;
`endif
                end
            end
            RUN: begin
                // Withdrawal wins over completion: no done when req drops.
                if (~|(req & gnt_q)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else if (count_q == len_q) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
            rr_q    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
`ifndef CNT_SCHED_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = busy_q;

endmodule
